sparse_index_match: RTL
=======================

# sparse_index_match

Index-intersection stage directly downstream of the sparse decoder. It consumes two decoded sparse-vector streams (A and B) of (index, value) beats with ascending indices and compares head indices. It forwards only index-matched value pairs to the MAC accumulator, plus a vector-terminating beat. One comparison is made per cycle, and the output is registered.

## Interface
Parameters:
- VALUE_W, package constant: width of each value.
- INDEX_W, package constant: width of each index.

Ports (name, direction, width, meaning):
- mac_clk, in, 1: the single clock.
- mac_rst, in, 1: reset, synchronous, active-high.
- a_valid_i, in, 1: stream A beat valid.
- a_ready_o, out, 1: stream A beat consumed this cycle when high together with a_valid_i.
- a_data_i, in, decoder_data_t: stream A value and index.
- a_last_i, in, 1: the A beat is the final element of vector A.
- b_valid_i, b_ready_o, b_data_i, b_last_i: same as the A ports, for stream B.
- out_valid_o, out, 1: output beat valid.
- out_ready_i, in, 1: downstream accepts the output beat.
- out_data_o, out, match_data_t: index, a_value, b_value, match, last.

## Operation
- State machine with states CMP, DRAIN_A and DRAIN_B. Reset state is CMP.
- CMP requires both heads valid; nothing is consumed if either is missing.
  - a.index < b.index: pop A, no output.
  - a.index > b.index: pop B, no output.
  - Equal indices: pop both and emit a match beat: match=1, index, a_value, b_value.
- A "producing pop" is any pop that emits a beat.
  - A producing pop is allowed only when the output register is empty, or out_ready_i=1 this cycle.
  - A non-producing pop is never blocked by the output stage.
- End-of-vector handling:
  - Popped beats both carry last (equal indices): the match beat has last=1, then return to CMP.
  - Only the popped A beat is last (by compare or by match): go to DRAIN_B.
  - Only the popped B beat is last: go to DRAIN_A, symmetric to DRAIN_B.
  - In a match beat, last=1 only if both streams end on it.
- DRAIN_B: pop every B beat without output (non-producing) until the B last beat.
  - That beat is a producing pop.
  - It emits a terminator beat: match=0, last=1, index=0, values=0.
  - Then go to CMP.
- DRAIN_A: symmetric to DRAIN_B.
- Both last beats popped in the same cycle with unequal indices cannot occur. Only one stream is popped on unequal indices, so the other stream continues as in DRAIN.
- a_ready_o and b_ready_o are combinational from state, head valids, head indices and the output-stage condition. Never assert a ready whose pop is not taken.
- Inputs must have strictly ascending indices within a vector. This is not checked.
- Value fields pass through unmodified. Index comparison is unsigned, INDEX_W bits.

## Timing
- Reset values: out_valid_o=0, out_data_o=0, a_ready_o=0, b_ready_o=0, state=CMP.
- Latency: a producing pop in cycle N gives out_valid_o=1 in cycle N+1.
- Throughput: one pop decision per cycle. A full output register drains and reloads in the same cycle when out_ready_i=1.
- Output hold: while out_valid_o=1 and out_ready_i=0, out_data_o is held stable. Producing pops stall, non-producing pops continue.
- Reset mid-vector: state returns to CMP and the output register is cleared. Partially consumed input beats are lost; upstream is reset with the same reset.

## Structure
- sparse_mac_pkg holds the shared definitions:
  - match_data_t: INDEX_W index, VALUE_W a_value, VALUE_W b_value, match, last.
  - The state enum: CMP, DRAIN_A, DRAIN_B.
  - decoder_data_t and VALUE_W/INDEX_W already live there.
- The output register is instantiated as a single-entry pipe register with valid/ready.
  - The existing skid_buffer is not reused, because of its reset polarity.
  - Comparator and FSM stay in the top module.

## Test plan
- A={(1,10),(4,11),(7,12,last)}, B={(4,20),(7,21,last)}, out_ready=1 -> beats (4,11,20,m=1,l=0), (7,12,21,m=1,l=1); exactly 2 beats.
- A={(2,5,last)}, B={(1,3),(3,4),(9,6,last)} -> zero match beats; a single terminator (m=0,l=1) after B index 9 is popped; state returns to CMP.
- Disjoint A={(0,1),(2,1,last)}, B={(1,1),(3,1,last)} -> one terminator only.
- Same stimulus as the first scenario with out_ready low for 5 cycles on the first match -> out_data held stable; no producing pop; index 7 emitted only after the hold is released; no beat lost or duplicated.
- Random streams (lengths 1–32, indices 0–63), random valid/ready stalls, 1000 vectors -> output matches a scoreboard intersection; one last per vector pair.
- Assert mac_rst for one cycle mid-vector, after 2 matches -> next cycle out_valid=0, state CMP; fresh vectors after reset produce correct results.

Source files
------------

// File: rtl/sparse_mac_pkg.sv
// Shared types for the sparse MAC datapath: decoder beats, match beats and
// the index-intersection state encoding.
package sparse_mac_pkg;

  localparam int VALUE_W = 16;
  localparam int INDEX_W = 8;

  typedef struct packed {
    logic [INDEX_W-1:0] index;
    logic [VALUE_W-1:0] value;
  } decoder_data_t;

  typedef struct packed {
    logic [INDEX_W-1:0] index;
    logic [VALUE_W-1:0] a_value;
    logic [VALUE_W-1:0] b_value;
    logic               match;
    logic               last;
  } match_data_t;

  typedef enum logic [1:0] {
    CMP     = 2'd0,
    DRAIN_A = 2'd1,
    DRAIN_B = 2'd2
  } match_state_e;

endpackage

// File: rtl/sparse_index_match_pipe_reg.sv
// Single-entry valid/ready pipe register; drains and reloads in one cycle
// when downstream is ready.
module sparse_index_match_pipe_reg
  import sparse_mac_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  match_data_t in_data_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output match_data_t out_data_o
);

  logic        valid_q, valid_d;
  match_data_t data_q, data_d;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_valid_i && in_ready_o) begin
      valid_d = 1'b1;
      data_d  = in_data_i;
    end else if (valid_q && out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/sparse_index_match.sv
// Index intersection of two ascending sparse streams: forwards matched value
// pairs plus one vector-terminating beat through a registered output.
module sparse_index_match
  import sparse_mac_pkg::*;
(
  input  logic          mac_clk,
  input  logic          mac_rst,
  input  logic          a_valid_i,
  output logic          a_ready_o,
  input  decoder_data_t a_data_i,
  input  logic          a_last_i,
  input  logic          b_valid_i,
  output logic          b_ready_o,
  input  decoder_data_t b_data_i,
  input  logic          b_last_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output match_data_t   out_data_o,
  output match_state_e  state_o
);

  // Handshake: a beat moves on a port in the cycle where valid and ready are
  // both high at the clock edge; readys never depend on the same port's ready.
  match_state_e state_q, state_d;
  logic         a_pop, b_pop, emit, out_free;
  match_data_t  emit_data;

  assign a_ready_o = a_pop;
  assign b_ready_o = b_pop;
  assign state_o   = state_q;

  always_comb begin
    state_d   = state_q;
    a_pop     = 1'b0;
    b_pop     = 1'b0;
    emit      = 1'b0;
    emit_data = '0;
    if (!mac_rst) begin
      case (state_q)
        CMP: begin
          if (a_valid_i && b_valid_i) begin
            if (a_data_i.index < b_data_i.index) begin
              a_pop = 1'b1;
              if (a_last_i) state_d = DRAIN_B;
            end else if (a_data_i.index > b_data_i.index) begin
              b_pop = 1'b1;
              if (b_last_i) state_d = DRAIN_A;
            end else if (out_free) begin
              a_pop             = 1'b1;
              b_pop             = 1'b1;
              emit              = 1'b1;
              emit_data.index   = a_data_i.index;
              emit_data.a_value = a_data_i.value;
              emit_data.b_value = b_data_i.value;
              emit_data.match   = 1'b1;
              emit_data.last    = a_last_i && b_last_i;
              if (a_last_i && !b_last_i) state_d = DRAIN_B;
              else if (b_last_i && !a_last_i) state_d = DRAIN_A;
            end
          end
        end
        DRAIN_B: begin
          // Only the final B beat produces output (the terminator).
          if (b_valid_i) begin
            if (!b_last_i) begin
              b_pop = 1'b1;
            end else if (out_free) begin
              b_pop          = 1'b1;
              emit           = 1'b1;
              emit_data.last = 1'b1;
              state_d        = CMP;
            end
          end
        end
        DRAIN_A: begin
          if (a_valid_i) begin
            if (!a_last_i) begin
              a_pop = 1'b1;
            end else if (out_free) begin
              a_pop          = 1'b1;
              emit           = 1'b1;
              emit_data.last = 1'b1;
              state_d        = CMP;
            end
          end
        end
        default: state_d = CMP;
      endcase
    end
  end

  always_ff @(posedge mac_clk) begin
    if (mac_rst) state_q <= CMP;
    else         state_q <= state_d;
  end

  sparse_index_match_pipe_reg u_out_reg (
    .clk         (mac_clk),
    .rst         (mac_rst),
    .in_valid_i  (emit),
    .in_ready_o  (out_free),
    .in_data_i   (emit_data),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o)
  );

endmodule
